// File: rtl/cop0_pkg.sv
// Shared definitions for the coprocessor-0 block: register numbers,
// Status/Cause bit positions, MTC0 write masks, reset values and the
// exception-code enumeration.
package cop0_pkg;

    // Register numbers (MFC0/MTC0 rd field)
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;
    localparam logic [4:0] REG_ERROREPC = 5'd30;

    // Status bit positions
    localparam int ST_IE  = 0;
    localparam int ST_EXL = 1;
    localparam int ST_ERL = 2;
    localparam int ST_IM0 = 8;
    localparam int ST_BEV = 22;

    // Cause bit positions
    localparam int CA_SWIP0 = 8;

    // Bits that software may change through MTC0
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0004;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // A fault in a delay slot restarts at the branch, one word earlier.
    function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cop0_timer.sv
// Count/Compare timer for coprocessor 0.
//   clk, reset     : clock, asynchronous active-high reset
//   count_we       : load Count from wdata (also restarts the half-rate phase)
//   compare_we     : load Compare from wdata (also clears TI)
//   wdata          : MTC0 data
//   count, compare : current register values
//   ti             : timer interrupt flag
module cop0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        phase_q, phase_d;
    logic        ti_q, ti_d;

    always_comb begin
        // Count advances on cycles where the phase flop is 0, i.e. every other cycle.
        count_d   = phase_q ? count_q : (count_q + 32'd1);
        phase_d   = ~phase_q;
        if (count_we) begin
            count_d = wdata;
            phase_d = 1'b0;
        end

        compare_d = compare_we ? wdata : compare_q;

        // Match detection uses the registered values; a Compare write wins.
        ti_d = ti_q;
        if (compare_we) begin
            ti_d = 1'b0;
        end else if (count_q == compare_q) begin
            ti_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            phase_q   <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            phase_q   <= phase_d;
            ti_q      <= ti_d;
        end
    end

    assign count   = count_q;
    assign compare = compare_q;
    assign ti      = ti_q;

endmodule

// File: rtl/cop0_unit.sv
// Coprocessor-0 register file and exception state.
//   clk, reset         : clock, asynchronous active-high reset
//   raddr / rdata      : MFC0 read port (combinational from registered state)
//   we, waddr, wdata   : MTC0 write port
//   eret               : ERET commit (clears ERL if set, else EXL)
//   exc_*              : exception commit with code, PC, delay-slot flag, BadVAddr
//   hw_int             : level-sensitive external interrupts
//   epc_out            : ERET target
//   exc_vector         : current exception vector (depends on Status.BEV)
//   irq                : interrupt pending and enabled
//   status_exl/erl     : Status.EXL / Status.ERL
module cop0_unit
    import cop0_pkg::*;
#(
    parameter logic [31:0] PRID            = 32'h0001_8000,
    parameter logic [31:0] EXC_VECTOR_BEV  = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VECTOR_NORM = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic        eret,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        exc_badvaddr_valid,
    input  logic [31:0] exc_badvaddr,
    input  logic [5:0]  hw_int,
    output logic [31:0] epc_out,
    output logic [31:0] exc_vector,
    output logic        irq,
    output logic        status_exl,
    output logic        status_erl
);

    logic [31:0] status_q, status_d;
    logic        bd_q, bd_d;
    logic [4:0]  code_q, code_d;
    logic [1:0]  sw_ip_q, sw_ip_d;
    logic [5:0]  hw_ip_q;
    logic [31:0] epc_q, epc_d;
    logic [31:0] errorepc_q, errorepc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    logic [31:0] count, compare;
    logic        ti;
    logic        eret_en, mtc0_en;
    logic [7:0]  ip;
    logic [31:0] cause_rd;
    logic [31:0] cause_wr;

    // Exception beats ERET beats MTC0; losers are dropped for the cycle.
    assign eret_en = eret & ~exc_valid;
    assign mtc0_en = we & ~exc_valid & ~eret;

    cop0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (mtc0_en && (waddr == REG_COUNT)),
        .compare_we (mtc0_en && (waddr == REG_COMPARE)),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti)
    );

    // IP7 shares the highest hardware line with the timer.
    assign ip       = {hw_ip_q[5] | ti, hw_ip_q[4:0], sw_ip_q};
    assign cause_rd = {bd_q, ti, 14'd0, ip, 1'b0, code_q, 2'b00};
    assign cause_wr = wdata & CAUSE_WMASK;

    always_comb begin
        status_d   = status_q;
        bd_d       = bd_q;
        code_d     = code_q;
        sw_ip_d    = sw_ip_q;
        epc_d      = epc_q;
        errorepc_d = errorepc_q;
        badvaddr_d = badvaddr_q;

        if (exc_valid) begin
            code_d = exc_code;
            // A nested exception keeps the original EPC/BD so the outer
            // handler can still return to the first fault.
            if (!status_q[ST_EXL]) begin
                epc_d            = restart_pc(exc_pc, exc_bd);
                bd_d             = exc_bd;
                status_d[ST_EXL] = 1'b1;
            end
            if (exc_badvaddr_valid) begin
                badvaddr_d = exc_badvaddr;
            end
        end else if (eret_en) begin
            if (status_q[ST_ERL]) begin
                status_d[ST_ERL] = 1'b0;
            end else begin
                status_d[ST_EXL] = 1'b0;
            end
        end else if (mtc0_en) begin
            case (waddr)
                REG_STATUS:   status_d   = wdata & STATUS_WMASK;
                REG_CAUSE:    sw_ip_d    = cause_wr[CA_SWIP0 +: 2];
                REG_EPC:      epc_d      = wdata;
                REG_ERROREPC: errorepc_d = wdata;
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q   <= STATUS_RESET;
            bd_q       <= 1'b0;
            code_q     <= 5'd0;
            sw_ip_q    <= 2'd0;
            hw_ip_q    <= 6'd0;
            epc_q      <= 32'd0;
            errorepc_q <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            status_q   <= status_d;
            bd_q       <= bd_d;
            code_q     <= code_d;
            sw_ip_q    <= sw_ip_d;
            hw_ip_q    <= hw_int;
            epc_q      <= epc_d;
            errorepc_q <= errorepc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    always_comb begin
        case (raddr)
            REG_BADVADDR: rdata = badvaddr_q;
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = status_q;
            REG_CAUSE:    rdata = cause_rd;
            REG_EPC:      rdata = epc_q;
            REG_PRID:     rdata = PRID;
            REG_ERROREPC: rdata = errorepc_q;
            default:      rdata = 32'd0;
        endcase
    end

    assign status_exl = status_q[ST_EXL];
    assign status_erl = status_q[ST_ERL];
    assign epc_out    = status_q[ST_ERL] ? errorepc_q : epc_q;
    assign exc_vector = status_q[ST_BEV] ? EXC_VECTOR_BEV : EXC_VECTOR_NORM;
    assign irq        = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL]
                        & (|(ip & status_q[ST_IM0 +: 8]));

endmodule

// File: tb/tb_cop0_unit.sv
// Self-checking bench for cop0_unit: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the architectural registers.
module tb_cop0_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  raddr = '0;
    logic [31:0] rdata;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        eret = 1'b0;
    logic        exc_valid = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_pc = '0;
    logic        exc_bd = 1'b0;
    logic        exc_badvaddr_valid = 1'b0;
    logic [31:0] exc_badvaddr = '0;
    logic [5:0]  hw_int = '0;
    logic [31:0] epc_out;
    logic [31:0] exc_vector;
    logic        irq;
    logic        status_exl;
    logic        status_erl;

    int errors = 0;
    int checks = 0;

    cop0_unit dut (
        .clk                (clk),
        .reset              (reset),
        .raddr              (raddr),
        .rdata              (rdata),
        .we                 (we),
        .waddr              (waddr),
        .wdata              (wdata),
        .eret               (eret),
        .exc_valid          (exc_valid),
        .exc_code           (exc_code),
        .exc_pc             (exc_pc),
        .exc_bd             (exc_bd),
        .exc_badvaddr_valid (exc_badvaddr_valid),
        .exc_badvaddr       (exc_badvaddr),
        .hw_int             (hw_int),
        .epc_out            (epc_out),
        .exc_vector         (exc_vector),
        .irq                (irq),
        .status_exl         (status_exl),
        .status_erl         (status_erl)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Count is modelled as "value loaded + half the cycles elapsed since".
    logic [31:0] m_cnt_base = 0;
    longint      m_cnt_n = 0;
    logic [31:0] m_compare = 0, m_status = 32'h0040_0004, m_epc = 0, m_errorepc = 0, m_badv = 0;
    logic        m_ti = 0, m_bd = 0;
    logic [4:0]  m_code = 0;
    logic [1:0]  m_swip = 0;
    logic [5:0]  m_hw = 0;

    function automatic logic [31:0] m_count();
        longint v;
        v = longint'(m_cnt_base) + (m_cnt_n + 1) / 2;
        return v[31:0];
    endfunction

    task automatic m_reset();
        m_cnt_base = 0; m_cnt_n = 0; m_compare = 0; m_status = 32'h0040_0004;
        m_epc = 0; m_errorepc = 0; m_badv = 0; m_ti = 0; m_bd = 0;
        m_code = 0; m_swip = 0; m_hw = 0;
    endtask

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_swip};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count();
            5'd11: return m_compare;
            5'd12: return m_status;
            5'd13: return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'b00};
            5'd14: return m_epc;
            5'd15: return 32'h0001_8000;
            5'd30: return m_errorepc;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_irq();
        return m_status[0] && !m_status[1] && !m_status[2] && ((m_ip() & m_status[15:8]) != 8'd0);
    endfunction

    task automatic m_step();
        logic [31:0] cnow;
        logic        wr;
        cnow = m_count();
        wr = we && !exc_valid && !eret;
        // timer: compare write clears, otherwise a match sets
        if (wr && waddr == 5'd11) m_ti = 1'b0;
        else if (cnow == m_compare) m_ti = 1'b1;
        if (wr && waddr == 5'd9) begin
            m_cnt_base = wdata; m_cnt_n = 0;
        end else begin
            m_cnt_n = m_cnt_n + 1;
        end
        m_hw = hw_int;
        if (exc_valid) begin
            m_code = exc_code;
            if (!m_status[1]) begin
                m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
                m_bd = exc_bd;
                m_status[1] = 1'b1;
            end
            if (exc_badvaddr_valid) m_badv = exc_badvaddr;
        end else if (eret) begin
            if (m_status[2]) m_status[2] = 1'b0;
            else m_status[1] = 1'b0;
        end else if (wr) begin
            case (waddr)
                5'd11: m_compare = wdata;
                5'd12: m_status = wdata & 32'h0040_FF07;
                5'd13: m_swip = wdata[9:8];
                5'd14: m_epc = wdata;
                5'd30: m_errorepc = wdata;
                default: ;
            endcase
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (raddr=%0d) at %0t", name, act, exp, raddr, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("rdata", rdata, m_read(raddr));
        chk("epc_out", epc_out, m_status[2] ? m_errorepc : m_epc);
        chk("exc_vector", exc_vector, m_status[22] ? 32'hBFC0_0380 : 32'h8000_0180);
        chk("irq", {31'd0, irq}, {31'd0, m_irq()});
        chk("status_exl", {31'd0, status_exl}, {31'd0, m_status[1]});
        chk("status_erl", {31'd0, status_erl}, {31'd0, m_status[2]});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
        $display("MTC0 r%0d <= %h", a, d);
    endtask

    task automatic rd_expect(input string name, input logic [4:0] a, input logic [31:0] exp);
        raddr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         input logic bv, input logic [31:0] bva);
        exc_valid = 1'b1; exc_code = code; exc_pc = pc; exc_bd = bd;
        exc_badvaddr_valid = bv; exc_badvaddr = bva;
        tick();
        exc_valid = 1'b0; exc_badvaddr_valid = 1'b0;
        $display("EXC code=%0d pc=%h bd=%0d", code, pc, bd);
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        $display("ERET");
    endtask

    logic [4:0] reg_list [9] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd30, 5'd0};
    logic [4:0] code_list [7] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

    function automatic logic [4:0] pick_reg();
        int k;
        k = $urandom_range(0, 8);
        return (k == 8) ? 5'($urandom) : reg_list[k];
    endfunction

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exc_valid = ($urandom_range(0, 15) == 0);
            exc_code = code_list[$urandom_range(0, 6)];
            exc_pc = $urandom & 32'hFFFF_FFFC;
            exc_bd = 1'($urandom);
            exc_badvaddr_valid = 1'($urandom);
            exc_badvaddr = $urandom;
            eret = ($urandom_range(0, 9) == 0);
            we = ($urandom_range(0, 2) == 0);
            waddr = pick_reg();
            wdata = $urandom;
            if (waddr == 5'd9 || waddr == 5'd11) wdata = $urandom_range(0, 40);
            if (waddr == 5'd12 && $urandom_range(0, 1) == 1) begin
                wdata[2:1] = 2'b00;
                wdata[0] = 1'b1;
            end
            hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            raddr = pick_reg();
            tick();
            $display("RND %0d we=%0d wa=%0d eret=%0d exc=%0d ra=%0d rdata=%h irq=%0d",
                     i, we, waddr, eret, exc_valid, raddr, rdata, irq);
        end
        we = 1'b0; eret = 1'b0; exc_valid = 1'b0; exc_badvaddr_valid = 1'b0; hw_int = 6'd0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        tick();

        // Reset state
        rd_expect("reset_status", 5'd12, 32'h0040_0004);
        chk("reset_vector", exc_vector, 32'hBFC0_0380);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_erl", {31'd0, status_erl}, 32'd1);
        rd_expect("prid", 5'd15, 32'h0001_8000);

        // ERET with ERL=1 clears only ERL and switches epc_out to EPC
        mtc0(5'd30, 32'h1234_5678);
        mtc0(5'd14, 32'h8000_0ABC);
        chk("epc_out_erl", epc_out, 32'h1234_5678);
        do_eret();
        chk("eret1_erl", {31'd0, status_erl}, 32'd0);
        chk("eret1_exl", {31'd0, status_exl}, 32'd0);
        chk("epc_out_epc", epc_out, 32'h8000_0ABC);

        // Timer: TI and irq assert 10 cycles after the Count write
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd5);
        repeat (8) tick();
        rd_expect("ti_before", 5'd13, 32'h0000_0000);
        chk("irq_before", {31'd0, irq}, 32'd0);
        tick();
        rd_expect("ti_set", 5'd13, 32'h4000_8000);
        chk("irq_set", {31'd0, irq}, 32'd1);
        rd_expect("count_at_ti", 5'd9, 32'd5);
        mtc0(5'd11, 32'd100);
        rd_expect("ti_clear", 5'd13, 32'h0000_0000);
        chk("irq_clear", {31'd0, irq}, 32'd0);

        // Exception in a delay slot
        raise(5'd12, 32'h8000_1004, 1'b1, 1'b0, 32'd0);
        rd_expect("dslot_epc", 5'd14, 32'h8000_1000);
        rd_expect("dslot_cause", 5'd13, 32'h8000_0030);
        chk("dslot_exl", {31'd0, status_exl}, 32'd1);
        chk("dslot_irq", {31'd0, irq}, 32'd0);

        // Nested exception keeps EPC/BD, loads ExcCode and BadVAddr
        raise(5'd4, 32'h8000_2000, 1'b0, 1'b1, 32'h0000_0003);
        rd_expect("nest_epc", 5'd14, 32'h8000_1000);
        rd_expect("nest_cause", 5'd13, 32'h8000_0010);
        rd_expect("nest_badv", 5'd8, 32'h0000_0003);

        // ERET with ERL=0 clears EXL
        do_eret();
        chk("eret2_exl", {31'd0, status_exl}, 32'd0);
        chk("eret2_epc_out", epc_out, 32'h8000_1000);

        // Exception + ERET + MTC0 Status=0 in one cycle: exception wins
        exc_valid = 1'b1; exc_code = 5'd8; exc_pc = 32'h8000_3000; exc_bd = 1'b0;
        eret = 1'b1; we = 1'b1; waddr = 5'd12; wdata = 32'd0;
        tick();
        exc_valid = 1'b0; eret = 1'b0; we = 1'b0;
        $display("COLLIDE exc+eret+mtc0");
        chk("collide_exl", {31'd0, status_exl}, 32'd1);
        rd_expect("collide_status", 5'd12, 32'h0000_8003);
        rd_expect("collide_epc", 5'd14, 32'h8000_3000);
        do_eret();

        // Cause write only reaches the software interrupt bits
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd_expect("cause_mask", 5'd13, 32'h0000_0320);
        // BadVAddr and PRId ignore writes
        mtc0(5'd8, 32'hDEAD_BEEF);
        rd_expect("badv_ro", 5'd8, 32'h0000_0003);
        mtc0(5'd15, 32'hDEAD_BEEF);
        rd_expect("prid_ro", 5'd15, 32'h0001_8000);

        // Randomized traffic checked by the model on every cycle
        random_cycles(1500);

        // Reset asserted mid-operation
        #1 reset = 1'b1;
        $display("RESET asserted mid-run");
        rd_expect("midrst_status", 5'd12, 32'h0040_0004);
        rd_expect("midrst_count", 5'd9, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        random_cycles(300);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
